// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter: the sequencing states,
// the default RAM geometry, and the width of a port index.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int MEM_ADDR_WIDTH = 9;
    localparam int MEM_DATA_WIDTH = 32;

    // Width needed to hold a port number; a single-bit index is kept even for one port.
    function automatic int port_idx_width(input int nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first eligible port found when
// scanning upward from ptr+1, wrapping modulo NPORTS.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    localparam int IW = port_idx_width(NPORTS)
) (
    input  logic [NPORTS-1:0] eligible,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] winner,
    output logic [IW-1:0]     winner_idx,
    output logic              any
);

    int            p;
    logic [IW-1:0] cand;

    // NOTE: every output gets a default before the loop so no path through it can infer a latch.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        p          = 0;
        cand       = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            p = int'(ptr) + k;
            if (p >= NPORTS) begin
                p = p - NPORTS;
            end
            cand = IW'(p);
            if (!any && eligible[cand]) begin
                any          = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM among NPORTS requesters. Each access
// runs as an ACCESS/RESP pair and completes with a one-cycle done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORTS     = 3,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [NPORTS-1:0]            req,
    input  logic [NPORTS-1:0]            we,
    input  logic [NPORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NPORTS*DATA_WIDTH-1:0] wdata,
    output logic [NPORTS-1:0]            gnt,
    output logic [NPORTS-1:0]            done,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [ADDR_WIDTH-1:0]        ram_address,
    output logic [DATA_WIDTH-1:0]        ram_in,
    output logic                         ram_enable_write,
    output logic                         ram_enable_read,
    input  logic [DATA_WIDTH-1:0]        ram_out
);

    localparam int            IW        = port_idx_width(NPORTS);
    localparam logic [IW-1:0] PTR_RESET = IW'(NPORTS - 1);

    arb_state_t state_q, state_d;

    logic [IW-1:0]         ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;

    logic [NPORTS-1:0]     eligible;
    logic [NPORTS-1:0]     win;
    logic [IW-1:0]         win_idx;
    logic                  win_any;
    logic                  take;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;

    // A port is masked in its own done cycle, and the current owner is masked in RESP.
    always_comb begin
        eligible = req & ~done & ((state_q == RESP) ? ~gnt : {NPORTS{1'b1}});
        take     = win_any && ((state_q == IDLE) || (state_q == RESP));
    end

    rr_pick #(.NPORTS(NPORTS)) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .winner    (win),
        .winner_idx(win_idx),
        .any       (win_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (win[i]) begin
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = we[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = take ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            ptr_q   <= PTR_RESET;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            done <= (state_q == RESP) ? gnt : '0;
            if ((state_q == RESP) && !we_q) begin
                rdata <= ram_out;
            end
            if (take) begin
                gnt     <= win;
                ptr_q   <= win_idx;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                we_q    <= sel_we;
            end else if (state_q == RESP) begin
                gnt <= '0;
            end
        end
    end

    // RAM controls come only from registered state, so a clear drops them at once.
    always_comb begin
        ram_address      = '0;
        ram_in           = '0;
        ram_enable_write = 1'b0;
        ram_enable_read  = 1'b0;
        if (state_q == ACCESS) begin
            ram_address      = addr_q;
            ram_in           = wdata_q;
            ram_enable_write = we_q;
            ram_enable_read  = ~we_q;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous RAM (9-bit word address, 32-bit data, one-cycle registered read) among NPORTS requesters.
- Typical requesters: port 0 is the program loader/debug, port 1 is CPU data (ld/st), port 2 is CPU instruction fetch.
- Sequences each access as a fixed ACCESS/RESP pair and returns read data over a req/gnt/done handshake.
- Arbitration is round-robin, so fetch cannot starve data traffic and data cannot starve fetch.

Parameters:
- NPORTS, 3, number of requesters (2..4).
- ADDR_WIDTH, 9, RAM word address width.
- DATA_WIDTH, 32, RAM data width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clear  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  NPORTS  per-port access request.
- we  in  NPORTS  per-port write select (1 = write, 0 = read); meaningful only while req is high.
- addr  in  NPORTS*ADDR_WIDTH  per-port word address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NPORTS*DATA_WIDTH  per-port write data, packed the same way.
- gnt  out  NPORTS  one-hot; owner of the RAM during ACCESS and RESP.
- done  out  NPORTS  one-hot, one-cycle pulse on completion.
- rdata  out  DATA_WIDTH  read data of the last completed read; valid while done is high, held until the next read completes.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_in  out  DATA_WIDTH  to RAM write data.
- ram_enable_write  out  1  to RAM write enable.
- ram_enable_read  out  1  to RAM read enable.
- ram_out  in  DATA_WIDTH  from RAM registered read data.

Behaviour:
- Reset (clear=0, async):
  - state=IDLE; gnt, done, rdata all 0.
  - Latched addr/wdata/we = 0; ram_* outputs = 0.
  - Round-robin pointer = NPORTS-1, so port 0 has first priority.
- States:
  - IDLE: no access in progress.
  - ACCESS: ram_enable_read = ~we_q, ram_enable_write = we_q, ram_address = addr_q, ram_in = wdata_q. The RAM performs the operation at the end of this cycle.
  - RESP: ram_out is valid; both enables are 0.
- RAM enables and address/data are decoded from registered state only, never from the req inputs.
- Arbitration, evaluated in IDLE and in RESP:
  - Eligible set = req & ~done & ~(RESP ? owner : 0).
  - Winner = first eligible port scanning from pointer+1 upward, wrapping modulo NPORTS.
  - On a winner at the clock edge: latch addr/we/wdata, set owner/gnt one-hot, set pointer = winner, go to ACCESS.
  - No winner: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS -> RESP unconditionally.
- At the edge leaving RESP:
  - done[owner] <= 1 for exactly one cycle.
  - rdata <= ram_out if the access was a read; unchanged on a write.
  - gnt clears unless a new winner is taken.
- Timing for a single isolated read (request seen in cycle 0):
  - Cycle 0: req high, state IDLE.
  - Cycle 1: ACCESS, gnt high.
  - Cycle 2: RESP, gnt high.
  - Cycle 3: done high, rdata valid.
  - Latency is 3 cycles. Sustained throughput is one access per 2 cycles, because RESP can hand directly to ACCESS for another port.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable from assertion until its done.
  - A port's req is ignored in its own done cycle; a back-to-back request from the same port is seen from done+1 onward.
  - Input changes during gnt have no effect because values are latched.
- Write: RAM is updated at the end of ACCESS; done follows 2 cycles later, and rdata is not modified.
- Reset mid-operation: enables drop immediately with the state. A clear asserted during ACCESS before the edge suppresses the write. No done is issued for the aborted access, and the requester must re-request.
- Address width is ADDR_WIDTH exactly; no range check (0x1FF wraps naturally in the RAM).

Decomposition:
- Package mem_arb_pkg holds:
  - state enumeration (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - a port-index width function.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot winner, winner index, any.
- All sequencing stays in mem_port_arbiter.

Test Plan:
- Single read, port 1, addr 0, RAM preloaded 0x09000069 at word 0 -> gnt[1] in cycles 1-2, ram_enable_read only in cycle 1, done[1] in cycle 3, rdata=0x09000069.
- Port 0 writes 0xDEADBEEF to 0x8E, then port 2 reads 0x8E -> ram_enable_write one cycle; read done with rdata=0xDEADBEEF; rdata unchanged during the write's done.
- All three ports request at once after reset -> completion order 0,1,2; the same requests re-raised give order 0,1,2 again, with the pointer rotation verified after each grant.
- Ports 1 and 2 hold continuous read requests to addrs 5 and 6 -> done alternates 1,2,1,2 every 2 cycles; no cycle has both enables high; neither port waits more than 4 cycles.
- clear pulsed low during an ACCESS write to 0x10 -> ram_enable_write drops immediately, mem[0x10] keeps its old value, no done, all outputs 0; the next request is granted to port 0 first.
- Port 1 re-asserts req during its own done cycle -> ignored; a request held into done+1 is accepted with gnt at done+2.
